// File: rtl/hs_mon_pkg.sv
// Shared types for the handshake monitor: event kinds, channel FSM states,
// the default event record layout and the drop counter width.
package hs_mon_pkg;

    localparam int DROP_W     = 16;
    localparam int REC_CHAN_W = 8;
    localparam int REC_CYC_W  = 32;

    typedef enum logic [2:0] {
        EV_TRANSFER    = 3'd0,
        EV_TIMEOUT     = 3'd1,
        EV_DATA_CHANGE = 3'd2,
        EV_VALID_DROP  = 3'd3
    } ev_kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } ch_state_t;

    // Generic record; the top narrows chan/cycles to its own parameters.
    typedef struct packed {
        logic [REC_CHAN_W-1:0] chan;
        ev_kind_t              kind;
        logic [REC_CYC_W-1:0]  cycles;
    } ev_rec_t;

    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0] base,
        input int unsigned       inc
    );
        int unsigned sum;
        sum = 32'(base) + inc;
        if (sum > 32'(16'hFFFF)) begin
            return '1;
        end
        return DROP_W'(sum);
    endfunction

endpackage

// File: rtl/hs_event_fifo.sv
// First-word-fall-through synchronous FIFO of event records with an
// occupancy output; head is valid whenever empty is low.
module hs_event_fifo
    import hs_mon_pkg::*;
#(
    parameter type rec_t = ev_rec_t,
    parameter int  DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rec_t          push_rec,
    input  logic          pop,
    output rec_t          head,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // Storage is deliberately not reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

endmodule

// File: rtl/hs_monitor.sv
// Multi-channel valid/ready protocol monitor: per-channel stall checking,
// one pending slot per channel, round-robin arbitration into an event FIFO.
module hs_monitor
    import hs_mon_pkg::*;
#(
    parameter int  CHANNELS   = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  TIMEOUT    = 16,
    parameter int  CNT_W      = 16,
    parameter int  DEPTH      = 8,
    parameter int  LOG_XFER   = 1,
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           clear,
    input  logic [CHANNELS-1:0]            valid,
    input  logic [CHANNELS-1:0]            ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    output logic                           ev_valid,
    input  logic                           ev_ready,
    output logic [CHAN_W-1:0]              ev_chan,
    output logic [2:0]                     ev_kind,
    output logic [CNT_W-1:0]               ev_cycles,
    output logic [CHANNELS-1:0]            err_sticky,
    output logic [DROP_W-1:0]              drop_count,
    output logic [LVL_W-1:0]               fifo_level
);

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        ev_kind_t          kind;
        logic [CNT_W-1:0]  cycles;
    } rec_t;

    localparam logic [CNT_W-1:0]  TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(CHANNELS - 1);

    logic [CHANNELS-1:0] err_vec;
    logic [CHANNELS-1:0] slot_full;
    logic [CHANNELS-1:0] drop_vec;
    logic [CHANNELS-1:0] grant;
    rec_t                slot_rec [CHANNELS];
    logic [CHAN_W-1:0]   rr_ptr;
    logic [CHAN_W-1:0]   gnt_idx;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    rec_t                head;
    logic [LVL_W-1:0]    level;
    int                  idx;
    int unsigned         n_drop;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ch_state_t             state_q;
        ch_state_t             state_d;
        logic [DATA_WIDTH-1:0] snap_q;
        logic [DATA_WIDTH-1:0] snap_d;
        logic [DATA_WIDTH-1:0] cur;
        logic [CNT_W-1:0]      cnt_q;
        logic [CNT_W-1:0]      cnt_d;
        logic [CNT_W-1:0]      cnt_inc;
        logic                  to_done_q;
        logic                  to_done_d;
        logic                  changed;
        logic                  to_hit;
        logic                  fire;
        ev_kind_t              kind;
        logic [CNT_W-1:0]      cyc;
        logic                  err;
        logic                  slot_q;
        rec_t                  rec_q;

        assign cur     = data[i*DATA_WIDTH +: DATA_WIDTH];
        assign changed = (cur != snap_q);
        assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        assign to_hit  = !to_done_q && (cnt_inc >= TO_CNT);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                snap_q    <= '0;
                cnt_q     <= '0;
                to_done_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                snap_q    <= snap_d;
                cnt_q     <= cnt_d;
                to_done_q <= to_done_d;
            end
        end

        // to_done latches even when a DATA_CHANGE masks the TIMEOUT event.
        always_comb begin
            state_d   = state_q;
            snap_d    = snap_q;
            cnt_d     = cnt_q;
            to_done_d = to_done_q;
            if (!en) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                to_done_d = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid[i] && !ready[i]) begin
                            state_d   = ST_WAIT;
                            snap_d    = cur;
                            cnt_d     = CNT_ONE;
                            to_done_d = (TO_CNT <= CNT_ONE);
                        end
                    end
                    ST_WAIT: begin
                        if (!valid[i] || ready[i]) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            to_done_d = 1'b0;
                        end else begin
                            cnt_d     = cnt_inc;
                            to_done_d = to_done_q || to_hit;
                        end
                        if (valid[i] && changed) begin
                            snap_d = cur;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_comb begin
            fire = 1'b0;
            kind = EV_TRANSFER;
            cyc  = '0;
            err  = 1'b0;
            if (en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid[i] && ready[i]) begin
                            fire = (LOG_XFER != 0);
                        end else if (valid[i] && (TO_CNT <= CNT_ONE)) begin
                            fire = 1'b1;
                            kind = EV_TIMEOUT;
                            cyc  = TO_CNT;
                            err  = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!valid[i]) begin
                            fire = 1'b1;
                            kind = EV_VALID_DROP;
                            cyc  = cnt_q;
                            err  = 1'b1;
                        end else if (changed) begin
                            fire = 1'b1;
                            kind = EV_DATA_CHANGE;
                            cyc  = cnt_q;
                            err  = 1'b1;
                        end else if (!ready[i] && to_hit) begin
                            fire = 1'b1;
                            kind = EV_TIMEOUT;
                            cyc  = TO_CNT;
                            err  = 1'b1;
                        end else if (ready[i]) begin
                            fire = (LOG_XFER != 0);
                            cyc  = cnt_q;
                        end
                    end
                    default: fire = 1'b0;
                endcase
            end
        end

        // A slot being granted this cycle frees up in time to take a new event.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= 1'b0;
                rec_q  <= '0;
            end else if (fire && (!slot_q || grant[i])) begin
                slot_q <= 1'b1;
                rec_q  <= '{chan: CHAN_W'(i), kind: kind, cycles: cyc};
            end else if (grant[i]) begin
                slot_q <= 1'b0;
            end
        end

        assign slot_full[i] = slot_q;
        assign slot_rec[i]  = rec_q;
        assign err_vec[i]   = err;
        assign drop_vec[i]  = fire && slot_q && !grant[i];
    end

    // Full is checked alone so a same-cycle pop never opens a grant.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        push    = 1'b0;
        idx     = 0;
        if (!fifo_full) begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = (int'(rr_ptr) + k) % CHANNELS;
                if (!push && slot_full[idx]) begin
                    push       = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_idx    = CHAN_W'(idx);
                end
            end
        end
    end

    always_comb begin
        n_drop = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            n_drop = n_drop + 32'(drop_vec[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            err_sticky <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CHAN_W'(1);
            end
            err_sticky <= (clear ? '0 : err_sticky) | err_vec;
            drop_count <= clear ? DROP_W'(n_drop) : sat_add_drop(drop_count, n_drop);
        end
    end

    hs_event_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_rec (slot_rec[gnt_idx]),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (level)
    );

    assign ev_valid   = !fifo_empty;
    assign pop        = ev_valid && ev_ready;
    assign ev_chan    = ev_valid ? head.chan : '0;
    assign ev_kind    = ev_valid ? head.kind : 3'd0;
    assign ev_cycles  = ev_valid ? head.cycles : '0;
    assign fifo_level = level;

endmodule

// File: tb/tb_hs_monitor.sv
// Directed bench for hs_monitor: expected events are queued as stimulus is
// issued and a negedge monitor pops and compares every consumed event.
module tb_hs_monitor;

    localparam int K_TR = 0;
    localparam int K_TO = 1;
    localparam int K_DC = 2;
    localparam int K_VD = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clear;
    logic [3:0]   valid;
    logic [3:0]   ready;
    logic [127:0] data;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_chan;
    logic [2:0]   ev_kind;
    logic [15:0]  ev_cycles;
    logic [3:0]   err_sticky;
    logic [15:0]  drop_count;
    logic [3:0]   fifo_level;

    typedef struct packed {
        logic [1:0]  chan;
        logic [2:0]  kind;
        logic [15:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    hs_monitor #(
        .CHANNELS   (4),
        .DATA_WIDTH (32),
        .TIMEOUT    (4),
        .CNT_W      (16),
        .DEPTH      (8),
        .LOG_XFER   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .valid      (valid),
        .ready      (ready),
        .data       (data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_chan    (ev_chan),
        .ev_kind    (ev_kind),
        .ev_cycles  (ev_cycles),
        .err_sticky (err_sticky),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input logic v, input logic r, input logic [31:0] d);
        valid[ch]         = v;
        ready[ch]         = r;
        data[ch*32 +: 32] = d;
    endtask

    task automatic expectEvent(input int ch, input int kind, input int cycles);
        exp_q.push_back({2'(ch), 3'(kind), 16'(cycles)});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, want);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (!rst && ev_valid && ev_ready) begin
            got = {ev_chan, ev_kind, ev_cycles};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_event: got chan %0d kind %0d cycles %0d, expected none",
                         ev_chan, ev_kind, ev_cycles);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("[TB] FAIL event: got chan %0d kind %0d cycles %0d, expected chan %0d kind %0d cycles %0d",
                             got.chan, got.kind, got.cycles, want.chan, want.kind, want.cycles);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        clear    = 1'b0;
        ev_ready = 1'b0;
        valid    = '0;
        ready    = '0;
        data     = '0;
        tick(3);
        checkOutput("reset_ev_valid", 32'(ev_valid), 32'd0);
        checkOutput("reset_level", 32'(fifo_level), 32'd0);
        checkOutput("reset_err", 32'(err_sticky), 32'd0);
        checkOutput("reset_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;
        tick(1);

        // All channels complete together; RR starts at 0.
        for (int ch = 0; ch < 4; ch++) begin
            expectEvent(ch, K_TR, 0);
            applyStimulus(ch, 1'b1, 1'b1, 32'(ch));
        end
        tick(1);
        for (int ch = 0; ch < 4; ch++) applyStimulus(ch, 1'b0, 1'b0, 32'd0);
        tick(5);
        checkOutput("rr_level_peak", 32'(fifo_level), 32'd4);
        ev_ready = 1'b1;
        waitDrain("rr_drain");

        // ch0 three stall cycles then handshake.
        expectEvent(0, K_TR, 3);
        applyStimulus(0, 1'b1, 1'b0, 32'hA5);
        tick(3);
        applyStimulus(0, 1'b1, 1'b1, 32'hA5);
        tick(1);
        applyStimulus(0, 1'b0, 1'b0, 32'd0);
        waitDrain("stall3_drain");
        checkOutput("stall3_err", 32'(err_sticky), 32'd0);

        // ch1 data changes while stalled.
        expectEvent(1, K_DC, 2);
        expectEvent(1, K_TR, 3);
        applyStimulus(1, 1'b1, 1'b0, 32'h10);
        tick(2);
        applyStimulus(1, 1'b1, 1'b0, 32'h11);
        tick(1);
        applyStimulus(1, 1'b1, 1'b1, 32'h11);
        tick(1);
        applyStimulus(1, 1'b0, 1'b0, 32'd0);
        waitDrain("change_drain");
        checkOutput("change_err", 32'(err_sticky), 32'h2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checkOutput("clear_err", 32'(err_sticky), 32'd0);

        // ch2 ten stall cycles, timeout at 4.
        expectEvent(2, K_TO, 4);
        expectEvent(2, K_TR, 10);
        applyStimulus(2, 1'b1, 1'b0, 32'h3C);
        tick(10);
        applyStimulus(2, 1'b1, 1'b1, 32'h3C);
        tick(1);
        applyStimulus(2, 1'b0, 1'b0, 32'd0);
        waitDrain("timeout_drain");
        checkOutput("timeout_err", 32'(err_sticky), 32'h4);

        // Disabled mid-stall: silent return to idle.
        applyStimulus(0, 1'b1, 1'b0, 32'h1);
        tick(2);
        en = 1'b0;
        tick(2);
        applyStimulus(0, 1'b0, 1'b0, 32'd0);
        tick(2);
        en = 1'b1;
        tick(5);
        checkOutput("en_silent", 32'(ev_valid), 32'd0);

        // FIFO full with consumer stalled.
        ev_ready = 1'b0;
        for (int n = 0; n < 9; n++) expectEvent(0, K_TR, 0);
        applyStimulus(0, 1'b1, 1'b1, 32'h1);
        tick(12);
        applyStimulus(0, 1'b0, 1'b0, 32'd0);
        tick(2);
        checkOutput("full_level", 32'(fifo_level), 32'd8);
        checkOutput("full_drop", 32'(drop_count), 32'd3);
        ev_ready = 1'b1;
        waitDrain("full_drain");
        checkOutput("full_level_after", 32'(fifo_level), 32'd0);

        // Async reset mid-stall on ch3.
        applyStimulus(3, 1'b1, 1'b0, 32'h77);
        tick(2);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_ev_valid", 32'(ev_valid), 32'd0);
        checkOutput("async_level", 32'(fifo_level), 32'd0);
        checkOutput("async_err", 32'(err_sticky), 32'd0);
        checkOutput("async_drop", 32'(drop_count), 32'd0);
        checkOutput("async_head", {11'd0, ev_chan, ev_kind, ev_cycles}, 32'd0);
        tick(1);
        applyStimulus(3, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        tick(5);
        checkOutput("post_reset_quiet", 32'(ev_valid), 32'd0);

        // ch3 valid drop then zero-wait transfer.
        expectEvent(3, K_VD, 2);
        expectEvent(3, K_TR, 0);
        applyStimulus(3, 1'b1, 1'b0, 32'h5);
        tick(2);
        applyStimulus(3, 1'b0, 1'b0, 32'd0);
        tick(1);
        applyStimulus(3, 1'b1, 1'b1, 32'h6);
        tick(1);
        applyStimulus(3, 1'b0, 1'b0, 32'd0);
        waitDrain("drop_drain");
        checkOutput("drop_err", 32'(err_sticky), 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
